// File: rtl/register_file_pkg.sv
// Shared CPU definitions: datapath widths, the hardwired-zero register index and
// the encodings of the register-dump state machine.
package cpu_defs;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dumpState_e;
endpackage

// File: rtl/register_file_dump_fsm.sv
// Dump sequencer: walks every register index once under a valid/ready handshake
// and signals completion with a single-cycle DumpDone pulse.
module reg_dump_fsm
    import cpu_defs::*;
#(
    parameter int ADDR_W = cpu_defs::ADDR_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              DumpStart,
    input  logic              DumpReady,
    output logic              DumpValid,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic              DumpBusy,
    output logic              DumpDone
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    dumpState_e state;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            DumpValid <= 1'b0;
            DumpBusy  <= 1'b0;
            DumpDone  <= 1'b0;
            DumpAddr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (DumpStart) begin
                        state     <= RUN;
                        DumpAddr  <= '0;
                        DumpValid <= 1'b1;
                        DumpBusy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Without DumpReady the current beat is held unchanged.
                    if (DumpValid && DumpReady) begin
                        if (DumpAddr == LAST_ADDR) begin
                            state     <= DONE;
                            DumpValid <= 1'b0;
                            DumpDone  <= 1'b1;
                        end else begin
                            DumpAddr <= DumpAddr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    DumpDone <= 1'b0;
                    DumpBusy <= 1'b0;
                    DumpAddr <= '0;
                end
                default: begin
                    state     <= IDLE;
                    DumpValid <= 1'b0;
                    DumpBusy  <= 1'b0;
                    DumpDone  <= 1'b0;
                    DumpAddr  <= '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/register_file.sv
// 32-entry GPR file with write-first bypass, registered A/B operand latches and a
// handshaked dump port that runs concurrently with CPU reads and writes.
module register_file
    import cpu_defs::*;
#(
    parameter int DATA_W   = cpu_defs::DATA_W,
    parameter int ADDR_W   = cpu_defs::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    input  logic              DumpStart,
    input  logic              DumpReady,
    output logic              DumpValid,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpBusy,
    output logic              DumpDone
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] opA_p0;
    logic [DATA_W-1:0] opB_p0;
    logic              writeEn;

    // Read rule shared by both operand ports and the dump port: hardwired zero
    // first, then the same-cycle write (write-first), then the stored value.
    function automatic logic [DATA_W-1:0] resolveRead(
        input logic [ADDR_W-1:0] rdAddr,
        input logic [DATA_W-1:0] stored,
        input logic              wrEn,
        input logic [ADDR_W-1:0] wrAddr,
        input logic [DATA_W-1:0] wrData
    );
        if (ZERO_REG != 0 && rdAddr == ZERO_IDX) return '0;
        if (wrEn && rdAddr == wrAddr) return wrData;
        return stored;
    endfunction

    assign writeEn = RegWre && !(ZERO_REG != 0 && WriteReg == ZERO_IDX);

    always_comb begin
        opA_p0   = resolveRead(ReadReg1, regs[ReadReg1], RegWre, WriteReg, WriteData);
        opB_p0   = resolveRead(ReadReg2, regs[ReadReg2], RegWre, WriteReg, WriteData);
        DumpData = resolveRead(DumpAddr, regs[DumpAddr], RegWre, WriteReg, WriteData);
    end

    // Stage p0 -> p1: storage update and operand latches.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            DataA <= '0;
            DataB <= '0;
        end else begin
            if (writeEn) regs[WriteReg] <= WriteData;
            DataA <= opA_p0;
            DataB <= opB_p0;
        end
    end

    reg_dump_fsm #(
        .ADDR_W(ADDR_W)
    ) u_dumpFsm (
        .CLK      (CLK),
        .Reset    (Reset),
        .DumpStart(DumpStart),
        .DumpReady(DumpReady),
        .DumpValid(DumpValid),
        .DumpAddr (DumpAddr),
        .DumpBusy (DumpBusy),
        .DumpDone (DumpDone)
    );
endmodule
